// File: rtl/receptor_morse_pkg.sv
// rtl/receptor_morse_pkg.sv - shared Morse timing constants and receiver state encoding
// Purpose: unit thresholds shared with the transmitter side, plus the receiver FSM states.
// Ports: none (package).
package receptor_morse_pkg;

  // Receiver FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MARK  = 2'd1,
    GAP   = 2'd2,
    SPACE = 2'd3
  } state_t;

  // Durations in Morse time units.
  localparam logic [3:0] DASH_UNITS     = 4'd2;
  localparam logic [3:0] CHAR_GAP_UNITS = 4'd2;
  localparam logic [3:0] WORD_GAP_UNITS = 4'd5;

  // Longest character the pattern register can hold.
  localparam logic [2:0] MAX_ELEMENTS   = 3'd5;

endpackage

// File: rtl/receptor_morse_if.sv
// rtl/receptor_morse_if.sv - keyed-line input and decoded-character outputs of the Morse receiver
// Purpose: bundles the receiver line input and its character/word event outputs.
// Ports: MORSE_IN (keyed line), PATTERN[4:0], LEN[2:0], CHAR_VALID, WORD_GAP, ERR.
//   master: drives MORSE_IN, observes the decoded outputs.
//   slave : the receiver itself.
interface receptor_morse_if;
  logic       MORSE_IN;
  logic [4:0] PATTERN;
  logic [2:0] LEN;
  logic       CHAR_VALID;
  logic       WORD_GAP;
  logic       ERR;

  modport master (
    output MORSE_IN,
    input  PATTERN, LEN, CHAR_VALID, WORD_GAP, ERR
  );

  modport slave (
    input  MORSE_IN,
    output PATTERN, LEN, CHAR_VALID, WORD_GAP, ERR
  );
endinterface

// File: rtl/receptor_morse_temporizador_unidad.sv
// rtl/receptor_morse_temporizador_unidad.sv - Morse unit prescaler with saturating unit counter
// Purpose: counts elapsed Morse units since the last CLR.
// Ports:
//   CLK   in  system clock
//   RST   in  synchronous active-high reset
//   CLR   in  restart prescaler and unit count (line edge)
//   UNITS out units elapsed, including a unit completing in this very cycle (0..15)
module temporizador_unidad #(
  parameter int CLKS_PER_UNIT = 50_000_000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       CLR,
  output logic [3:0] UNITS
);
  localparam int            PW         = $clog2(CLKS_PER_UNIT);
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLKS_PER_UNIT - 1);

  logic [PW-1:0] r_presc;
  logic [3:0]    r_units;
  logic          w_tick;
  logic          w_inc;

  assign w_tick = (r_presc == PRESC_LAST);
  assign w_inc  = w_tick && (r_units != 4'd15);

  always_ff @(posedge CLK) begin
    if (RST || CLR) begin
      r_presc <= '0;
      r_units <= '0;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + 1'b1;
      if (w_inc) begin
        r_units <= r_units + 4'd1;
      end
    end
  end

  // Count the unit that completes this cycle, so a mark of exactly one unit
  // reads 1 at its falling edge rather than a cycle late.
  assign UNITS = w_inc ? r_units + 4'd1 : r_units;
endmodule

// File: rtl/receptor_morse.sv
// rtl/receptor_morse.sv - Morse receiver: mark/space timing, dot/dash classification, character assembly
// Purpose: decodes an on/off keyed line into dot/dash patterns and word-gap events.
// Ports:
//   CLK  in  system clock
//   RST  in  synchronous active-high reset
//   bus  receptor_morse_if.slave: MORSE_IN in; PATTERN, LEN, CHAR_VALID, WORD_GAP, ERR out
module receptor_morse
  import receptor_morse_pkg::*;
#(
  parameter int CLKS_PER_UNIT = 50_000_000
) (
  input  logic               CLK,
  input  logic               RST,
  receptor_morse_if.slave    bus
);
  logic       r_sync1, r_sync2, r_sync_d;
  logic       w_rise, w_fall;
  logic [3:0] w_units;
  logic       w_dash;

  state_t     r_state, w_state_nxt;
  logic [2:0] r_cnt, w_cnt_nxt;
  logic       r_ovf, w_ovf_nxt;
  logic [4:0] r_sh, w_sh_nxt;
  logic [4:0] r_pattern, w_pattern_nxt;
  logic [2:0] r_len, w_len_nxt;
  logic       r_char_valid, w_char_valid_nxt;
  logic       r_word_gap, w_word_gap_nxt;
  logic       r_err, w_err_nxt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_sync_d <= 1'b0;
    end else begin
      r_sync1  <= bus.MORSE_IN;
      r_sync2  <= r_sync1;
      r_sync_d <= r_sync2;
    end
  end

  assign w_rise = r_sync2 & ~r_sync_d;
  assign w_fall = ~r_sync2 & r_sync_d;

  temporizador_unidad #(.CLKS_PER_UNIT(CLKS_PER_UNIT)) u_temporizador (
    .CLK   (CLK),
    .RST   (RST),
    .CLR   (w_rise | w_fall),
    .UNITS (w_units)
  );

  assign w_dash = (w_units >= DASH_UNITS);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_ovf        <= 1'b0;
      r_sh         <= '0;
      r_pattern    <= '0;
      r_len        <= '0;
      r_char_valid <= 1'b0;
      r_word_gap   <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_ovf        <= w_ovf_nxt;
      r_sh         <= w_sh_nxt;
      r_pattern    <= w_pattern_nxt;
      r_len        <= w_len_nxt;
      r_char_valid <= w_char_valid_nxt;
      r_word_gap   <= w_word_gap_nxt;
      r_err        <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_ovf_nxt        = r_ovf;
    w_sh_nxt         = r_sh;
    w_pattern_nxt    = r_pattern;
    w_len_nxt        = r_len;
    w_char_valid_nxt = 1'b0;
    w_word_gap_nxt   = 1'b0;
    w_err_nxt        = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_rise) w_state_nxt = MARK;
      end
      MARK: begin
        if (w_fall) begin
          if (w_units == 4'd0) begin
            // Glitch: ignore it but keep assembling any character in progress.
            w_state_nxt = (r_cnt != 3'd0 || r_ovf) ? GAP : IDLE;
          end else begin
            if (r_cnt == MAX_ELEMENTS) begin
              w_ovf_nxt = 1'b1;
            end else begin
              w_sh_nxt  = r_sh | (5'(w_dash) << r_cnt);
              w_cnt_nxt = r_cnt + 3'd1;
            end
            w_state_nxt = GAP;
          end
        end
      end
      GAP: begin
        // The character is emitted even if a new mark starts on the same cycle.
        if (w_units == CHAR_GAP_UNITS) begin
          if (r_ovf) begin
            w_err_nxt = 1'b1;
          end else begin
            w_char_valid_nxt = 1'b1;
            w_pattern_nxt    = r_sh;
            w_len_nxt        = r_cnt;
          end
          w_cnt_nxt   = '0;
          w_ovf_nxt   = 1'b0;
          w_sh_nxt    = '0;
          w_state_nxt = w_rise ? MARK : SPACE;
        end else if (w_rise) begin
          w_state_nxt = MARK;
        end
      end
      SPACE: begin
        if (w_rise) begin
          w_state_nxt = MARK;
        end else if (w_units == WORD_GAP_UNITS) begin
          w_word_gap_nxt = 1'b1;
          w_state_nxt    = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign bus.PATTERN    = r_pattern;
  assign bus.LEN        = r_len;
  assign bus.CHAR_VALID = r_char_valid;
  assign bus.WORD_GAP   = r_word_gap;
  assign bus.ERR        = r_err;
endmodule
